// File: rtl/mem_arbiter_if.sv
// Cache-to-memory-control handshake bundle: icache and dcache request
// channels, the RAM model channel and the sticky error flag.
interface mem_arbiter_if #(
   parameter int WORD_W = 32
);
   // instruction side
   logic              iREN;
   logic [WORD_W-1:0] iaddr;
   logic              iwait;
   logic [WORD_W-1:0] iload;
   // data side
   logic              dREN;
   logic              dWEN;
   logic [WORD_W-1:0] daddr;
   logic [WORD_W-1:0] dstore;
   logic              dwait;
   logic [WORD_W-1:0] dload;
   // RAM side
   logic              ramREN;
   logic              ramWEN;
   logic [WORD_W-1:0] ramaddr;
   logic [WORD_W-1:0] ramstore;
   logic [WORD_W-1:0] ramload;
   logic [1:0]        ramstate;
   // status
   logic              mem_err;

   // arbiter view (responder)
   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
   );

   // caches plus RAM model view (requesters and memory)
   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Memory arbiter: single-ported RAM shared by icache and dcache. Data
// requests win by default, but after MAX_D_STREAK back-to-back data grants
// a pending fetch is forced through. Transfers that never see ACCESS are
// aborted after TIMEOUT cycles and flagged on the sticky mem_err.
module mem_arbiter #(
   parameter int WORD_W       = 32,
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic          CLK,
   input  logic          nRST,
   mem_arbiter_if.slave  bus
);
   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
   localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT);
   localparam logic [1:0]    RS_ACCESS  = 2'd2;
   localparam logic [1:0]    RS_ERROR   = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      IXFER = 2'd1,
      DXFER = 2'd2
   } arbState_t;

   arbState_t     state_r, nextState_s;
   logic [SW-1:0] streak_r, streakNext_s;
   logic [TW-1:0] tmo_r;
   logic          memErr_r, errSet_s;
   logic          dReq_s, access_s, fault_s;

   assign dReq_s   = bus.dREN | bus.dWEN;
   assign access_s = (bus.ramstate == RS_ACCESS);
   // a completed access takes precedence over a coincident timeout
   assign fault_s  = (bus.ramstate == RS_ERROR) || (tmo_r == TMO_MAX);
   assign bus.mem_err = memErr_r;

   // Next-state decode and RAM/cache handshake outputs for the current state
   always_comb begin
      nextState_s  = state_r;
      streakNext_s = streak_r;
      errSet_s     = 1'b0;
      bus.iwait    = 1'b1;
      bus.dwait    = 1'b1;
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = {WORD_W{1'b0}};
      bus.ramstore = {WORD_W{1'b0}};
      bus.iload    = bus.ramload;
      bus.dload    = bus.ramload;
      case (state_r)
         IDLE: begin
            if (!bus.iREN) begin
               streakNext_s = {SW{1'b0}};
            end else begin
               streakNext_s = streak_r;
            end
            if (dReq_s && !(bus.iREN && (streak_r == STREAK_MAX))) begin
               nextState_s = DXFER;
            end else if (bus.iREN) begin
               nextState_s = IXFER;
            end else begin
               nextState_s = IDLE;
            end
         end
         IXFER: begin
            bus.ramaddr = bus.iaddr;
            if (!bus.iREN) begin
               // icache hit: request withdrawn, enables drop this cycle
               nextState_s = IDLE;
            end else begin
               bus.ramREN = 1'b1;
               if (access_s) begin
                  bus.iwait    = 1'b0;
                  streakNext_s = {SW{1'b0}};
                  nextState_s  = IDLE;
               end else if (fault_s) begin
                  errSet_s    = 1'b1;
                  nextState_s = IDLE;
               end else begin
                  nextState_s = IXFER;
               end
            end
         end
         DXFER: begin
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
            if (!dReq_s) begin
               nextState_s = IDLE;
            end else begin
               // a write wins when both enables are raised
               bus.ramWEN = bus.dWEN;
               bus.ramREN = bus.dREN & ~bus.dWEN;
               if (access_s) begin
                  bus.dwait   = 1'b0;
                  nextState_s = IDLE;
                  if (streak_r != STREAK_MAX) begin
                     streakNext_s = streak_r + SW'(1);
                  end else begin
                     streakNext_s = streak_r;
                  end
               end else if (fault_s) begin
                  errSet_s    = 1'b1;
                  nextState_s = IDLE;
               end else begin
                  nextState_s = DXFER;
               end
            end
         end
         default: begin
            nextState_s = IDLE;
         end
      endcase
   end

   // State, grant streak, transfer timeout counter and sticky error flag
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r  <= IDLE;
         streak_r <= {SW{1'b0}};
         tmo_r    <= {TW{1'b0}};
         memErr_r <= 1'b0;
      end else begin
         state_r  <= nextState_s;
         streak_r <= streakNext_s;
         // every transfer is entered from IDLE, so clearing there restarts it
         if (state_r == IDLE) begin
            tmo_r <= {TW{1'b0}};
         end else begin
            tmo_r <= tmo_r + TW'(1);
         end
         if (errSet_s) begin
            memErr_r <= 1'b1;
         end else begin
            memErr_r <= memErr_r;
         end
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, write, arbitration fairness,
// fetch abort, timeout/error flagging and asynchronous reset.
module tb_mem_arbiter;
   logic CLK = 1'b0;
   logic nRST = 1'b0;
   int   nChecks = 0;
   int   nPass = 0;

   mem_arbiter_if #(.WORD_W(32)) bus ();

   mem_arbiter #(.WORD_W(32), .MAX_D_STREAK(4), .TIMEOUT(255)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) nPass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic doReset();
      nRST = 1'b0;
      bus.iREN = 1'b0; bus.iaddr = 32'h0;
      bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = 32'h0; bus.dstore = 32'h0;
      bus.ramload = 32'h0; bus.ramstate = 2'd0;
      repeat (2) @(posedge CLK);
      #3 nRST = 1'b1;
   endtask

   initial begin
      logic [9:0] expOrder;
      int   g;
      logic both;
      logic bad;

      // reset state
      doReset();
      #1;
      chk("rst_iwait", bus.iwait, 32'd1);
      chk("rst_dwait", bus.dwait, 32'd1);
      chk("rst_ramREN", bus.ramREN, 32'd0);
      chk("rst_ramWEN", bus.ramWEN, 32'd0);
      chk("rst_ramaddr", bus.ramaddr, 32'h0);
      chk("rst_ramstore", bus.ramstore, 32'h0);
      chk("rst_mem_err", bus.mem_err, 32'd0);

      // instruction fetch, ACCESS two cycles after ramREN
      step();
      bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = 2'd1;
      #1;
      chk("if_idle_ramREN", bus.ramREN, 32'd0);
      step(); #1;
      chk("if_ramREN", bus.ramREN, 32'd1);
      chk("if_ramaddr", bus.ramaddr, 32'h40);
      chk("if_wait_busy", bus.iwait, 32'd1);
      step(); #1;
      chk("if_wait_busy2", bus.iwait, 32'd1);
      step();
      bus.ramstate = 2'd2; bus.ramload = 32'hDEADBEEF;
      #1;
      chk("if_iwait_done", bus.iwait, 32'd0);
      chk("if_iload", bus.iload, 32'hDEADBEEF);
      chk("if_dwait_done", bus.dwait, 32'd1);
      step();
      bus.iREN = 1'b0;
      #1;
      chk("if_back_idle", bus.ramREN, 32'd0);
      chk("if_iwait_idle", bus.iwait, 32'd1);

      // data write with both enables raised
      doReset();
      bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h80;
      bus.dstore = 32'h12345678; bus.ramstate = 2'd1;
      step(); #1;
      chk("wr_ramWEN", bus.ramWEN, 32'd1);
      chk("wr_ramREN", bus.ramREN, 32'd0);
      chk("wr_ramstore", bus.ramstore, 32'h12345678);
      chk("wr_ramaddr", bus.ramaddr, 32'h80);
      chk("wr_dwait_busy", bus.dwait, 32'd1);
      step();
      bus.ramstate = 2'd2;
      #1;
      chk("wr_dwait_done", bus.dwait, 32'd0);
      chk("wr_iwait_done", bus.iwait, 32'd1);

      // data read returns ramload
      step();
      bus.dWEN = 1'b0; bus.ramload = 32'hA5A5_0F0F;
      #1;
      chk("rd_idle_ramREN", bus.ramREN, 32'd0);
      step(); #1;
      chk("rd_ramREN", bus.ramREN, 32'd1);
      chk("rd_dwait", bus.dwait, 32'd0);
      chk("rd_dload", bus.dload, 32'hA5A5_0F0F);

      // fairness: both sides requesting, ACCESS every XFER cycle
      doReset();
      bus.iREN = 1'b1; bus.dREN = 1'b1; bus.ramstate = 2'd2;
      expOrder = 10'b1000010000;   // bit k set: grant k goes to the icache
      g = 0;
      both = 1'b0;
      for (int c = 0; c < 40 && g < 10; c++) begin
         step(); #1;
         if (!bus.iwait && !bus.dwait) begin
            both = 1'b1;
         end else if (!bus.iwait || !bus.dwait) begin
            chk($sformatf("grant%0d_is_i", g), {31'b0, !bus.iwait}, {31'b0, expOrder[g]});
            g++;
         end
      end
      chk("grant_count", g, 32'd10);
      chk("no_dual_ack", {31'b0, both}, 32'd0);

      // fetch withdrawn before ACCESS (icache hit)
      doReset();
      bus.iREN = 1'b1; bus.iaddr = 32'h100; bus.ramstate = 2'd1;
      step(); #1;
      chk("ab_ramREN", bus.ramREN, 32'd1);
      step();
      bus.iREN = 1'b0;
      #1;
      chk("ab_ramREN_drop", bus.ramREN, 32'd0);
      chk("ab_iwait", bus.iwait, 32'd1);
      step();
      bus.ramstate = 2'd2;
      #1;
      chk("ab_no_stray_iwait", bus.iwait, 32'd1);
      chk("ab_idle_ramREN", bus.ramREN, 32'd0);

      // timeout: BUSY held for 256 transfer cycles
      doReset();
      bus.dREN = 1'b1; bus.ramstate = 2'd1;
      step(); #1;
      chk("to_enter_ramREN", bus.ramREN, 32'd1);
      bad = 1'b0;
      for (int c = 0; c < 255; c++) begin
         step(); #1;
         if (bus.dwait !== 1'b1 || bus.ramREN !== 1'b1) bad = 1'b1;
      end
      chk("to_held_in_dxfer", {31'b0, bad}, 32'd0);
      chk("to_err_not_yet", bus.mem_err, 32'd0);
      step(); #1;
      chk("to_mem_err", bus.mem_err, 32'd1);
      chk("to_idle_ramREN", bus.ramREN, 32'd0);
      chk("to_dwait", bus.dwait, 32'd1);
      step();
      bus.dREN = 1'b0;
      repeat (3) step();
      chk("to_err_sticky", bus.mem_err, 32'd1);

      // ERROR from the RAM also raises mem_err
      doReset();
      chk("er_cleared_by_rst", bus.mem_err, 32'd0);
      bus.dREN = 1'b1; bus.ramstate = 2'd3;
      step(); #1;
      chk("er_dwait", bus.dwait, 32'd1);
      step(); #1;
      chk("er_mem_err", bus.mem_err, 32'd1);

      // asynchronous reset mid write transfer
      doReset();
      bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'h55; bus.ramstate = 2'd3;
      step(); step(); #1;
      chk("ar_err_set", bus.mem_err, 32'd1);
      bus.ramstate = 2'd1;
      step(); #1;
      chk("ar_ramWEN_pre", bus.ramWEN, 32'd1);
      #2 nRST = 1'b0;
      #1;
      chk("ar_ramWEN", bus.ramWEN, 32'd0);
      chk("ar_dwait", bus.dwait, 32'd1);
      chk("ar_mem_err", bus.mem_err, 32'd0);
      bus.ramstate = 2'd2;
      #2 nRST = 1'b1;
      #1;
      chk("ar_idle_ramWEN", bus.ramWEN, 32'd0);
      chk("ar_idle_dwait", bus.dwait, 32'd1);
      step(); #1;
      chk("ar_regrant_ramWEN", bus.ramWEN, 32'd1);
      chk("ar_regrant_dwait", bus.dwait, 32'd0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder end of the cache-to-memory-control handshake.
- Accepts instruction-fetch requests (iREN/iaddr) from the icache and load/store requests (dREN/dWEN/daddr/dstore) from the dcache.
- Arbitrates between them, drives the single-ported RAM, and returns iwait/dwait plus load data.
- Sits between both caches and the RAM model; one requester per side (single core).

Parameters:
- WORD_W, 32, data and address width (matches word_t).
- MAX_D_STREAK, 4, consecutive data grants allowed while iREN is pending before the instruction side is forced.
- TIMEOUT, 255, cycles a granted transfer may wait for ramstate==ACCESS before being aborted as an error.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request from icache.
- iaddr  in  WORD_W  instruction address.
- iwait  out  1  instruction wait; 0 for exactly the cycle iload is valid.
- iload  out  WORD_W  instruction data.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  WORD_W  data address.
- dstore  in  WORD_W  write data.
- dwait  out  1  data wait; 0 for exactly the completing cycle.
- dload  out  WORD_W  read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- mem_err  out  1  sticky error flag.

Behaviour:
- Reset (async, nRST=0): state IDLE; iwait=dwait=1; ramREN=ramWEN=0; ramaddr=ramstore=0; mem_err=0; streak and timeout counters=0.
- States: IDLE, IXFER, DXFER.

IDLE:
- RAM enables are 0 and both waits are 1.
- Next state is decided from the current-cycle requests:
  - (dREN|dWEN) and not (iREN and streak==MAX_D_STREAK) -> DXFER.
  - else iREN -> IXFER.
  - else stay IDLE.
- Arbitration costs exactly 1 cycle.

DXFER:
- ramaddr=daddr, ramstore=dstore.
- If dWEN, then ramWEN=1 and ramREN=0. If only dREN, then ramREN=1. dWEN takes priority when both are high.
- dload=ramload combinationally.
- ramstate==ACCESS -> dwait=0 that cycle; next state IDLE; streak+=1 (saturating at MAX_D_STREAK).
- Requester drops both dREN and dWEN before ACCESS -> abort: RAM enables drop the same cycle, dwait stays 1, next state IDLE, streak unchanged.

IXFER:
- ramaddr=iaddr, ramREN=1, iload=ramload.
- ramstate==ACCESS -> iwait=0 that cycle; next state IDLE; streak cleared to 0.
- Abort on iREN drop mirrors DXFER. This is required: the icache deasserts iREN combinationally on a hit.

Streak and timeout:
- Streak clears to 0 in any IDLE cycle with iREN=0.
- Timeout counter clears on entry to an XFER state and increments each XFER cycle without ACCESS.

Error handling:
- In an XFER state, ramstate==ERROR or counter==TIMEOUT -> mem_err<=1 (sticky until reset); wait stays 1; next state IDLE; the requester retries.

Common rules:
- Never assert iwait=0 and dwait=0 in the same cycle.
- Never assert ramREN and ramWEN together.
- Outside XFER states, iload and dload still mirror ramload; their value is don't-care.
- Addresses and data pass through unmodified; no alignment checks.
- Minimum latency from request to wait=0 is 2 cycles: request in cycle 0, XFER with ACCESS in cycle 1.
- Reset asserted mid-transfer: enables drop and the waits rise immediately (asynchronous); no completion is reported.

Test Plan:
- iREN=1, iaddr=0x40, RAM returns ACCESS 2 cycles after ramREN with ramload=0xDEADBEEF -> ramaddr=0x40; iwait=0 for one cycle with iload=0xDEADBEEF; then IDLE.
- iREN and dREN asserted together continuously, ramstate ACCESS every XFER cycle -> grant order D,D,D,D,I,D,D,D,D,I; iwait and dwait never low together.
- dREN=dWEN=1, daddr=0x80, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678; dwait=0 on ACCESS.
- iREN asserted, then dropped before ACCESS (icache hit) -> ramREN falls the same cycle, iwait stays 1, FSM returns to IDLE, no stray completion.
- DXFER with ramstate held BUSY for 256 cycles -> mem_err=1, dwait remains 1, FSM back in IDLE; a separate run with ramstate=ERROR also sets mem_err; mem_err clears only on nRST.
- nRST pulsed low mid-DXFER -> ramWEN=0, dwait=1, mem_err=0 immediately; the first request after release is arbitrated from IDLE.
